// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier (WIDTH x WIDTH -> 2*WIDTH) with a start/done handshake.
// Optional macro BOOTH_EARLY_TERM_EN adds a barrel-shift shortcut when the remaining steps are pure shifts.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshake: start is sampled only while busy is low (IDLE); the edge that
    // samples it is the accepting edge. done is high for exactly one cycle and
    // product is valid from that cycle until the next completed operation.

    logic [1:0]         state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q0_q, q0_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [WIDTH:0]     a_step;
    logic [WIDTH:0]     a_shr;
    logic [WIDTH-1:0]   q_shr;

    logic               et_hit;
    logic [2*WIDTH:0]   et_aq;

    always_comb begin
        case ({q_q[0], q0_q})
            2'b01:   a_step = a_q + m_q;
            2'b10:   a_step = a_q - m_q;
            default: a_step = a_q;
        endcase
        a_shr = {a_step[WIDTH], a_step[WIDTH:1]};
        q_shr = {a_step[0], q_q[WIDTH-1:1]};
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic [WIDTH:0]     one_sh;
    logic [WIDTH-1:0]   low_mask;

    // Uniform low multiplier bits (including Q0) mean every remaining step is "00" or "11".
    always_comb begin
        one_sh   = {{WIDTH{1'b0}}, 1'b1} << count_q;
        low_mask = one_sh[WIDTH-1:0] - {{(WIDTH-1){1'b0}}, 1'b1};
        et_hit   = (!q0_q && ((q_q & low_mask) == '0)) ||
                   ( q0_q && ((q_q & low_mask) == low_mask));
        et_aq    = $unsigned($signed({a_q, q_q}) >>> count_q);
    end
`else
    always_comb begin
        et_hit = 1'b0;
        et_aq  = '0;
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q0_d    = q0_q;
        count_d = count_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    q_d     = multiplier;
                    a_d     = '0;
                    q0_d    = 1'b0;
                    count_d = CW'(WIDTH);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (et_hit) begin
                    a_d     = et_aq[2*WIDTH:WIDTH];
                    q_d     = et_aq[WIDTH-1:0];
                    count_d = '0;
                    prod_d  = et_aq[2*WIDTH-1:0];
                    state_d = S_DONE;
                end else begin
                    a_d     = a_shr;
                    q_d     = q_shr;
                    q0_d    = q_q[0];
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        prod_d  = {a_shr[WIDTH-1:0], q_shr};
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q0_q    <= 1'b0;
            count_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q0_q    <= q0_d;
            count_q <= count_d;
            prod_q  <= prod_d;
        end
    end

    assign product   = prod_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: directed corners, abort/ignore cases and random pairs against plain signed multiply.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [7:0]  mcand, mplier;
  logic [15:0] product;
  logic        busy, done;
  logic [1:0]  dbg_state;

  logic        start16;
  logic [15:0] mcand16, mplier16;
  logic [31:0] product16;
  logic        busy16, done16;
  logic [1:0]  dbg_state16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [15:0] exp_q[$];
  int lat_q[$];
  logic [15:0] last_prod = '0;

`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  booth_mult_seq #(.WIDTH(8)) dut (
    .clk(clk), .clr(clr), .start(start), .multiplicand(mcand), .multiplier(mplier),
    .product(product), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .clr(clr), .start(start16), .multiplicand(mcand16), .multiplier(mplier16),
    .product(product16), .busy(busy16), .done(done16), .dbg_state(dbg_state16)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b);
    int ai, bi, p;
    ai = $signed(a);
    bi = $signed(b);
    p  = ai * bi;
    return p[15:0];
  endfunction

  // driver: waits for idle, pulses start for one accepting edge, pushes the expectation
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    exp_q.push_back(model8(a, b));
    lat_q.push_back(lat < 0 ? -1 : cyc + 1 + lat);
    @(negedge clk);
    start  = 1'b0;
    chk("product_held_after_start", product, last_prod);
    last_prod = model8(a, b);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      chk("done_one_cycle", prev_done, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        logic [15:0] e;
        int l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("product", product, e);
        if (l >= 0) chk("latency_cycle", cyc, l);
      end
    end
    prev_done = done;
  end

  initial begin
    int full;
    int e0;
    int n;
    int dc;
    full = 8;
    clr = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    start16 = 1'b0; mcand16 = '0; mplier16 = '0;
    #12;
    chk("reset_product", product, 16'h0000);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    clr = 1'b0;

    // 3*5 with handshake timing
    do_op(8'd3, 8'd5, full);
    wait_done();
    @(negedge clk);
    chk("busy_low_after_done", busy, 0);
    chk("done_low_after_pulse", done, 0);

    do_op(8'hF9, 8'd6, full);       // -7*6
    do_op(8'h80, 8'h80, full);      // -128*-128
    do_op(8'h80, 8'h7F, full);      // -128*127
    do_op(8'h7F, 8'hFF, full);      // 127*-1
    do_op(8'd5, 8'd0, EARLY ? 1 : full);
    do_op(8'd9, 8'hFF, EARLY ? 2 : full);
    wait_done();
    @(negedge clk);

    // start pulsed while busy must be ignored
    dc = done_cnt;
    do_op(8'd11, 8'hF3, EARLY ? -1 : full);
    repeat (2) @(negedge clk);
    mcand = 8'd100; mplier = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("ignored_start_single_done", done_cnt - dc, 1);
    chk("ignored_start_product", product, model8(8'd11, 8'hF3));

    // asynchronous abort mid-CALC
    dc = done_cnt;
    do_op(8'd37, 8'hA5, -1);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 16'h0000);
    exp_q.delete();
    lat_q.delete();
    last_prod = '0;
    @(negedge clk);
    clr = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);
    do_op(8'd2, 8'd2, EARLY ? -1 : full);
    wait_done();

    // WIDTH=16 corner
    @(negedge clk);
    mcand16 = 16'h7FFF; mplier16 = 16'h8000; start16 = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w16_done_seen", done16, 1);
    chk("w16_product", product16, 32'hC0008000);
    if (!EARLY) chk("w16_latency", cyc, e0 + 16);

    // random pairs
    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), EARLY ? -1 : full);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
